// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads a combinational ROM and
// buffers {pc, instr} pairs in a small in-order queue toward decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    output logic [15:0]                o_imem_addr,
    input  logic [31:0]                i_imem_data,
    input  logic                       i_redirect,
    input  logic [15:0]                i_redirect_pc,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [31:0]                o_instr,
    output logic [15:0]                o_pc,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];

    logic pop;
    logic can_push;
    logic push;
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    always_comb begin
        pop        = (count_q != '0) & i_ready;
        can_push   = (count_q < CntW'(DEPTH)) | pop;
        push       = can_push & ~i_redirect;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (i_redirect) begin
            // Flush wins over any concurrent push or pop.
            fetch_pc_d = {i_redirect_pc[15:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 16'd4;
                wr_ptr_d   = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
                instr_mem_q[wr_ptr_q] <= i_imem_data;
            end
        end
    end

    assign o_imem_addr = fetch_pc_q;
    assign o_valid     = (count_q != '0);
    assign o_instr     = instr_mem_q[rd_ptr_q];
    assign o_pc        = pc_mem_q[rd_ptr_q];
    assign o_count     = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC streams are queued when fetch
// is (re)started and compared against every accepted instruction.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        i_clk;
    logic        i_reset;
    logic [15:0] o_imem_addr;
    logic [31:0] i_imem_data;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [15:0] o_pc;
    logic [$clog2(DEPTH):0] o_count;

    logic [15:0] exp_q [$];
    int n_tests;
    int n_fail;
    int n_pops;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_imem_addr   (o_imem_addr),
        .i_imem_data   (i_imem_data),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_count       (o_count)
    );

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    assign i_imem_data = rom_word(o_imem_addr);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic start_stream(input logic [15:0] pc, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc + 16'(4 * i));
        end
    endtask

    // Score any handshake happening this cycle, then advance to 1 after the edge.
    task automatic cycle();
        logic [15:0] e;
        if (o_valid && i_ready && !i_redirect) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pop_pc", {16'h0, o_pc}, {16'h0, e});
                check_eq("pop_instr", o_instr, rom_word(e));
                n_pops++;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_pops(input int n, input int budget);
        int target;
        int b;
        target = n_pops + n;
        b = 0;
        while (n_pops < target && b < budget) begin
            cycle();
            b++;
        end
        if (n_pops < target) check_eq("pop_timeout", n_pops, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        n_tests = 0;
        n_fail = 0;
        n_pops = 0;
        i_reset = 1'b0;
        i_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 16'h0;

        // Reset state
        #12;
        check_eq("rst_valid", {31'h0, o_valid}, 32'h0);
        check_eq("rst_count", 32'(o_count), 32'h0);
        check_eq("rst_instr", o_instr, 32'h0);
        check_eq("rst_pc", {16'h0, o_pc}, 32'h0);
        check_eq("rst_addr", {16'h0, o_imem_addr}, {16'h0, RESET_PC});

        // Release and stream with ready high
        i_reset = 1'b1;
        i_ready = 1'b1;
        start_stream(RESET_PC, 64);
        check_eq("valid_pre", {31'h0, o_valid}, 32'h0);
        @(posedge i_clk);
        #1;
        check_eq("valid_rise", {31'h0, o_valid}, 32'h1);
        check_eq("first_pc", {16'h0, o_pc}, {16'h0, RESET_PC});
        run_pops(4, 8);

        // Async reset between edges
        #2;
        i_reset = 1'b0;
        #1;
        check_eq("async_valid", {31'h0, o_valid}, 32'h0);
        check_eq("async_count", 32'(o_count), 32'h0);
        check_eq("async_addr", {16'h0, o_imem_addr}, {16'h0, RESET_PC});
        i_ready = 1'b0;
        #1;
        i_reset = 1'b1;
        start_stream(RESET_PC, 64);

        // Stall fills the queue and freezes the fetch address
        repeat (5) cycle();
        check_eq("stall_count", 32'(o_count), 32'(DEPTH));
        check_eq("stall_addr", {16'h0, o_imem_addr}, 32'h0008);
        check_eq("stall_pc", {16'h0, o_pc}, 32'h0000);
        check_eq("stall_valid", {31'h0, o_valid}, 32'h1);
        i_ready = 1'b1;
        run_pops(3, 6);

        // Full with steady ready: one per cycle, occupancy pinned at DEPTH
        p0 = n_pops;
        repeat (20) begin
            check_eq("full_count", 32'(o_count), 32'(DEPTH));
            cycle();
        end
        check_eq("throughput", n_pops - p0, 32'd20);

        // Redirect while full, misaligned target
        i_ready = 1'b0;
        repeat (3) cycle();
        check_eq("full_before_redir", 32'(o_count), 32'(DEPTH));
        i_redirect = 1'b1;
        i_redirect_pc = 16'h0043;
        cycle();
        i_redirect = 1'b0;
        start_stream(16'h0040, 64);
        check_eq("redir_valid", {31'h0, o_valid}, 32'h0);
        check_eq("redir_count", 32'(o_count), 32'h0);
        cycle();
        check_eq("redir_valid2", {31'h0, o_valid}, 32'h1);
        check_eq("redir_pc", {16'h0, o_pc}, 32'h0040);
        check_eq("redir_instr", o_instr, rom_word(16'h0040));
        check_eq("redir_addr", {16'h0, o_imem_addr}, 32'h0044);
        repeat (2) cycle();
        check_eq("hold_pc", {16'h0, o_pc}, 32'h0040);
        check_eq("hold_instr", o_instr, rom_word(16'h0040));
        i_ready = 1'b1;
        run_pops(2, 4);

        // Redirect near top of address space: PC wraps
        i_redirect = 1'b1;
        i_redirect_pc = 16'hFFF8;
        cycle();
        i_redirect = 1'b0;
        start_stream(16'hFFF8, 64);
        check_eq("wrap_valid0", {31'h0, o_valid}, 32'h0);
        run_pops(4, 10);

        // Back-to-back redirects: last target wins
        i_redirect = 1'b1;
        i_redirect_pc = 16'h0100;
        cycle();
        check_eq("b2b_valid1", {31'h0, o_valid}, 32'h0);
        i_redirect_pc = 16'h0200;
        cycle();
        check_eq("b2b_valid2", {31'h0, o_valid}, 32'h0);
        check_eq("b2b_count", 32'(o_count), 32'h0);
        i_redirect = 1'b0;
        start_stream(16'h0200, 64);
        cycle();
        check_eq("b2b_valid3", {31'h0, o_valid}, 32'h1);
        check_eq("b2b_pc", {16'h0, o_pc}, 32'h0200);
        run_pops(3, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
